// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and result-slot state shared by the ALU arbiter slice
package alu_pkg;

  localparam logic [3:0] OP_ADD        = 4'b0000;
  localparam logic [3:0] OP_SUB        = 4'b0001;
  localparam logic [3:0] OP_AND        = 4'b0010;
  localparam logic [3:0] OP_OR         = 4'b0011;
  localparam logic [3:0] OP_XOR        = 4'b0100;
  localparam logic [3:0] OP_PASSA      = 4'b0101;
  localparam logic [3:0] OP_PASSB      = 4'b0110;
  localparam logic [3:0] OP_EQ         = 4'b0111;
  localparam logic [3:0] OP_ZA         = 4'b1000;
  localparam logic [3:0] OP_LT         = 4'b1001;
  localparam logic [3:0] OP_LAST_VALID = 4'b1001;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic logic op_supported(input logic [3:0] op);
    return op <= OP_LAST_VALID;
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 16-bit ALU; unsupported opcodes yield zero with err set
module alu
  import alu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [3:0]    oper_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] result_o,
  output logic          err_o,
  output logic          overflow_o
);

  logic [DW-1:0] sum;
  logic [DW-1:0] diff;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    err_o      = !op_supported(oper_i);
    case (oper_i)
      OP_ADD: begin
        result_o   = sum;
        overflow_o = (a_i[DW-1] == b_i[DW-1]) && (sum[DW-1] != a_i[DW-1]);
      end
      OP_SUB: begin
        result_o   = diff;
        overflow_o = (a_i[DW-1] != b_i[DW-1]) && (diff[DW-1] != a_i[DW-1]);
      end
      OP_AND:   result_o = a_i & b_i;
      OP_OR:    result_o = a_i | b_i;
      OP_XOR:   result_o = a_i ^ b_i;
      OP_PASSA: result_o = a_i;
      OP_PASSB: result_o = b_i;
      OP_EQ:    result_o = {{(DW-1){1'b0}}, a_i == b_i};
      OP_ZA:    result_o = {{(DW-1){1'b0}}, a_i == '0};
      OP_LT:    result_o = {{(DW-1){1'b0}}, b_i < a_i};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two requesters share one ALU through a round-robin arbiter and a one-entry result slot
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [3:0]    req0_oper,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [3:0]    req1_oper,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          rsp_zero
);

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_id_q, rsp_id_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_zero_q, rsp_zero_d;

  logic          slot_free;
  logic          grant;
  logic          accept;
  logic [3:0]    sel_oper;
  logic [DW-1:0] sel_a;
  logic [DW-1:0] sel_b;
  logic [DW-1:0] alu_result;
  logic          alu_err;
  logic          alu_ovf_unused;

  // Readiness depends only on valids, slot state and rsp_ready, never on operands.
  always_comb begin
    slot_free = rst_n && ((state_q == ST_EMPTY) || rsp_ready);
    grant     = (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
    accept    = slot_free && (req0_valid || req1_valid);
  end

  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  assign sel_oper = grant ? req1_oper : req0_oper;
  assign sel_a    = grant ? req1_a    : req0_a;
  assign sel_b    = grant ? req1_b    : req0_b;

  alu #(.DW(DW)) u_alu (
    .oper_i     (sel_oper),
    .a_i        (sel_a),
    .b_i        (sel_b),
    .result_o   (alu_result),
    .err_o      (alu_err),
    .overflow_o (alu_ovf_unused)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    rsp_zero_d   = rsp_zero_q;
    if (accept) begin
      state_d      = ST_FULL;
      last_grant_d = grant;
      rsp_data_d   = alu_result;
      rsp_id_d     = grant;
      rsp_err_d    = alu_err;
      rsp_zero_d   = (alu_result == '0);
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= 1'b1;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_zero  = rsp_zero_q;

endmodule
